// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and helpers shared by the elastic pipeline files.
//   MAX_STAGES  - largest supported slot count
//   cnt_width() - width of an occupancy counter for a given slot count
package pipeline_pkg;

    localparam int unsigned MAX_STAGES = 16;

    // Occupancy counter width: enough bits to hold 0..stages inclusive.
    function automatic int unsigned cnt_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/elastic_pipeline_if.sv
// elastic_pipeline_if: valid/ready bus around the elastic pipeline.
//   slave  modport - the pipeline side (takes valid_in/data_in/ready_in,
//                    drives ready_out/valid_out/data_out/count_out)
//   master modport - the environment side (mirror of slave)
// flush_in exists only when ELASTIC_PIPELINE_FLUSH_EN is defined.
interface elastic_pipeline_if #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 8
);
    import pipeline_pkg::*;

    localparam int unsigned CW = cnt_width(STAGES);

    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             ready_in;
    logic [CW-1:0]    count_out;
`ifdef ELASTIC_PIPELINE_FLUSH_EN
    logic             flush_in;
`endif

    modport slave (
`ifdef ELASTIC_PIPELINE_FLUSH_EN
        input  flush_in,
`endif
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out, count_out
    );

    modport master (
`ifdef ELASTIC_PIPELINE_FLUSH_EN
        output flush_in,
`endif
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, count_out
    );

endinterface

// File: rtl/pipeline_slot.sv
// pipeline_slot: one register slot of the elastic pipeline.
//   clk, rst_n - clock, async active-low reset (clears valid and payload)
//   load       - capture data_d as a new valid item
//   clear      - current item leaves downstream (ignored when load is set)
//   flush      - drop the item; overrides load and clear
//   data_d     - incoming payload
//   valid_q    - slot holds an item
//   data_q     - slot payload
module pipeline_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    // Valid bit: flush wins, then a reload, then emptying downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (clear) begin
            valid_q <= 1'b0;
        end
    end

    // Payload only moves with a real item, so empty slots keep stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load && !flush) begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: STAGES-deep bubble-collapsing valid/ready pipeline.
//   clk_in   - clock, all state on rising edge
//   rst_n_in - asynchronous active-low reset, empties every slot
//   bus      - elastic_pipeline_if.slave: valid_in/data_in/ready_out upstream,
//              valid_out/data_out/ready_in downstream, count_out occupancy,
//              flush_in when ELASTIC_PIPELINE_FLUSH_EN is defined
// Parameters: STAGES (1..MAX_STAGES), WIDTH (>= 1).
// Slot 0 faces upstream; slot STAGES-1 drives valid_out/data_out.
// ready_out is a combinational chain from ready_in through the slot valids.
module elastic_pipeline
    import pipeline_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 8
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    elastic_pipeline_if.slave   bus
);

    localparam int unsigned CW = cnt_width(STAGES);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] can_acc;
    logic [WIDTH-1:0]  pay [STAGES];
    logic              flush_w;
    logic              in_hs;
    logic              out_hs;
    logic [CW-1:0]     count_q;

`ifdef ELASTIC_PIPELINE_FLUSH_EN
    assign flush_w = bus.flush_in;
`else
    assign flush_w = 1'b0;
`endif

    // adv[i]: slot i's item may move on (next slot empty or itself moving).
    always_comb begin
        adv = '0;
        adv[STAGES-1] = bus.ready_in;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            adv[i] = !v[i+1] || adv[i+1];
        end
    end

    // Slot chain; a slot takes a new item when empty or when its item moves on.
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        if (i == 0) begin : g_head
            assign up_v = bus.valid_in;
            assign up_d = bus.data_in;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = pay[i-1];
        end
        assign can_acc[i] = !v[i] || adv[i];

        pipeline_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk_in),
            .rst_n   (rst_n_in),
            .load    (can_acc[i] && up_v),
            .clear   (adv[i]),
            .flush   (flush_w),
            .data_d  (up_d),
            .valid_q (v[i]),
            .data_q  (pay[i])
        );
    end

    assign bus.ready_out = can_acc[0] && !flush_w;
    assign bus.valid_out = v[STAGES-1] && !flush_w;
    assign bus.data_out  = pay[STAGES-1];

    assign in_hs  = bus.valid_in  && bus.ready_out;
    assign out_hs = bus.valid_out && bus.ready_in;

    // Occupancy counter tracks handshakes on both sides.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else if (flush_w) begin
            count_q <= '0;
        end else if (in_hs && !out_hs) begin
            count_q <= count_q + CW'(1);
        end else if (out_hs && !in_hs) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign bus.count_out = count_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed bench for elastic_pipeline, STAGES=3, WIDTH=8.
// Flush scenario is included when ELASTIC_PIPELINE_FLUSH_EN is defined.
module tb_elastic_pipeline;

    localparam int unsigned STAGES = 3;
    localparam int unsigned WIDTH  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    elastic_pipeline_if #(.STAGES(STAGES), .WIDTH(WIDTH)) bus ();

    elastic_pipeline #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int         n_chk  = 0;
    int         n_err  = 0;
    int         in_cnt = 0;
    int         in0;
    int         e;
    int         ent;
    int         ext;
    logic [7:0] got_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.ready_in = r;
    endtask

    // Record handshakes just before the edge, then move to 1 ns past it.
    task automatic step();
        #1;
        if (bus.valid_out && bus.ready_in) got_q.push_back(bus.data_out);
        if (bus.valid_in && bus.ready_out) in_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0);
`ifdef ELASTIC_PIPELINE_FLUSH_EN
        bus.flush_in = 1'b0;
`endif
        #2;
        check_eq("rst_valid", 32'(bus.valid_out), 32'd0);
        check_eq("rst_data",  32'(bus.data_out),  32'd0);
        check_eq("rst_count", 32'(bus.count_out), 32'd0);
        check_eq("rst_ready", 32'(bus.ready_out), 32'd1);
        step();
        step();
        rst_n = 1'b1;

        // Back-to-back stream 0x01..0x05 with ready_in high.
        got_q.delete();
        for (int c = 0; c < 8; c++) begin
            drive(c < 5, 8'(c + 1), 1'b1);
            step();
            e   = c + 1;
            ent = (e < 5) ? e : 5;
            ext = (e < 3) ? 0 : ((e - 3 > 5) ? 5 : e - 3);
            check_eq($sformatf("t1_valid_e%0d", e), 32'(bus.valid_out),
                     32'((e >= 3) && (e <= 7)));
            if ((e >= 3) && (e <= 7))
                check_eq($sformatf("t1_data_e%0d", e), 32'(bus.data_out), 32'(e - 2));
            check_eq($sformatf("t1_count_e%0d", e), 32'(bus.count_out), 32'(ent - ext));
            check_eq($sformatf("t1_ready_e%0d", e), 32'(bus.ready_out), 32'd1);
        end
        check_eq("t1_nout", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < got_q.size(); i++)
            check_eq($sformatf("t1_out%0d", i), 32'(got_q[i]), 32'(i + 1));

        // Stall: stream 0xA0.. with ready_in low, fills and backpressures.
        got_q.delete();
        in0 = in_cnt;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 8'hA0 + 8'(in_cnt - in0), 1'b0);
            step();
            if (c >= 3)
                check_eq($sformatf("t2_hold%0d", c), 32'(bus.data_out), 32'hA0);
        end
        check_eq("t2_accepted", 32'(in_cnt - in0), 32'd3);
        check_eq("t2_count",    32'(bus.count_out), 32'd3);
        check_eq("t2_ready",    32'(bus.ready_out), 32'd0);
        check_eq("t2_valid",    32'(bus.valid_out), 32'd1);
        check_eq("t2_data",     32'(bus.data_out),  32'hA0);

        // Release ready_in while full with valid_in high.
        drive(1'b1, 8'hA3, 1'b1);
        #1;
        check_eq("t3_ready_full_release", 32'(bus.ready_out), 32'd1);
        step();
        check_eq("t3_count", 32'(bus.count_out), 32'd3);
        check_eq("t3_accepted", 32'(in_cnt - in0), 32'd4);
        for (int c = 0; c < 12; c++) begin
            drive((in_cnt - in0) < 6, 8'hA0 + 8'(in_cnt - in0), 1'b1);
            step();
        end
        check_eq("t3_nout", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size(); i++)
            check_eq($sformatf("t3_out%0d", i), 32'(got_q[i]), 32'hA0 + 32'(i));
        check_eq("t3_count_end", 32'(bus.count_out), 32'd0);

        // Bubble collapse: one item, idle cycles, ready_in low.
        got_q.delete();
        drive(1'b1, 8'h3C, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        step();
        check_eq("t4_not_yet", 32'(bus.valid_out), 32'd0);
        step();
        check_eq("t4_valid", 32'(bus.valid_out), 32'd1);
        check_eq("t4_data",  32'(bus.data_out),  32'h3C);
        check_eq("t4_count", 32'(bus.count_out), 32'd1);
        check_eq("t4_ready", 32'(bus.ready_out), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        step();
        check_eq("t4_nout", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check_eq("t4_out", 32'(got_q[0]), 32'h3C);
        check_eq("t4_count_end", 32'(bus.count_out), 32'd0);

        // Reset mid-stream with two items held.
        got_q.delete();
        drive(1'b1, 8'h55, 1'b0);
        step();
        drive(1'b1, 8'h66, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        check_eq("t5_count_pre", 32'(bus.count_out), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_valid", 32'(bus.valid_out), 32'd0);
        check_eq("t5_count", 32'(bus.count_out), 32'd0);
        check_eq("t5_ready", 32'(bus.ready_out), 32'd1);
        check_eq("t5_data",  32'(bus.data_out),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        repeat (4) step();
        check_eq("t5_no_ghost", 32'(got_q.size()), 32'd0);
        drive(1'b1, 8'h77, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b1);
        step();
        check_eq("t5_lat_e2", 32'(bus.valid_out), 32'd0);
        step();
        check_eq("t5_lat_e3", 32'(bus.valid_out), 32'd1);
        check_eq("t5_lat_data", 32'(bus.data_out), 32'h77);
        step();
        check_eq("t5_nout", 32'(got_q.size()), 32'd1);

`ifdef ELASTIC_PIPELINE_FLUSH_EN
        // Flush with two items held and a simultaneous input offer.
        got_q.delete();
        drive(1'b1, 8'h11, 1'b0);
        step();
        drive(1'b1, 8'h22, 1'b0);
        step();
        check_eq("t6_count_pre", 32'(bus.count_out), 32'd2);
        in0 = in_cnt;
        drive(1'b1, 8'h99, 1'b0);
        bus.flush_in = 1'b1;
        #1;
        check_eq("t6_ready_mask", 32'(bus.ready_out), 32'd0);
        check_eq("t6_valid_mask", 32'(bus.valid_out), 32'd0);
        step();
        bus.flush_in = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        check_eq("t6_count", 32'(bus.count_out), 32'd0);
        check_eq("t6_valid", 32'(bus.valid_out), 32'd0);
        check_eq("t6_not_accepted", 32'(in_cnt - in0), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        repeat (4) step();
        check_eq("t6_no_out", 32'(got_q.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
